sprite_blitter: RTL and testbench

- Parametrised successor to the fixed single-symbol drawers: renders any of NUM_SYM bitmap symbols of SPR_W x SPR_H pixels at a base (x,y), one pixel per cycle, into the VGA adapter pixel port.
- Symbol bitmaps come row by row from an external synchronous ROM.
- Supports transparent draw, opaque draw and erase modes, screen-edge clipping, and a start/busy/done handshake with the game control FSM.

---
 rtl/sprite_blitter_if.sv | 39 +++
 rtl/sprite_blitter.sv | 184 ++++++++++++++++++
 tb/tb_sprite_blitter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Blit request, ROM row fetch and VGA pixel port shared by the game controller and sprite_blitter.
// The controller side (master) also owns the symbol ROM, so it drives rom_row.
interface sprite_blitter_if #(
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int NUM_SYM = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COL_W   = 3
);
  localparam int SW = $clog2(NUM_SYM);
  localparam int AW = $clog2(NUM_SYM * SPR_H);

  logic             start;
  logic [SW-1:0]    sym_sel;
  logic [1:0]       mode;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] fg_colour;
  logic [COL_W-1:0] bg_colour;
  logic [AW-1:0]    rom_addr;
  logic [SPR_W-1:0] rom_row;
  logic             busy;
  logic             done;
  logic             plot;
  logic [X_W-1:0]   xout;
  logic [Y_W-1:0]   yout;
  logic [COL_W-1:0] colour;

  modport master (
    output start, sym_sel, mode, x, y, fg_colour, bg_colour, rom_row,
    input  rom_addr, busy, done, plot, xout, yout, colour
  );

  modport slave (
    input  start, sym_sel, mode, x, y, fg_colour, bg_colour, rom_row,
    output rom_addr, busy, done, plot, xout, yout, colour
  );
endinterface

// File: rtl/sprite_blitter.sv
// Draws one SPR_W x SPR_H symbol from an external synchronous ROM, one pixel per cycle,
// with transparent/opaque/erase modes and clipping at the right and bottom screen edges.
module sprite_blitter #(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int NUM_SYM  = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COL_W    = 3
) (
  input logic             clk,
  input logic             reset,
  sprite_blitter_if.slave bus
);
  localparam int SW = $clog2(NUM_SYM);
  localparam int AW = $clog2(NUM_SYM * SPR_H);
  localparam int RW = $clog2(SPR_H);
  localparam int CW = $clog2(SPR_W);

  localparam logic [SW:0]    NUM_SYM_L = (SW + 1)'(NUM_SYM);
  localparam logic [AW-1:0]  SPR_H_A   = AW'(SPR_H);
  localparam logic [RW-1:0]  LAST_ROW  = RW'(SPR_H - 1);
  localparam logic [CW-1:0]  LAST_COL  = CW'(SPR_W - 1);
  localparam logic [X_W:0]   SCR_W_L   = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_H_L   = (Y_W + 1)'(SCREEN_H);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;

  logic [SW-1:0]    r_sym;
  logic [1:0]       r_mode;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [COL_W-1:0] r_fg;
  logic [COL_W-1:0] r_bg;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [SPR_W-1:0] r_shift;

  logic [AW-1:0]    r_rom_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_plot;
  logic [X_W-1:0]   r_xout;
  logic [Y_W-1:0]   r_yout;
  logic [COL_W-1:0] r_colour;

  logic [SW-1:0]    w_sym_in;
  logic [RW-1:0]    w_fetch_row;
  logic [AW-1:0]    w_rom_addr;
  logic [CW-1:0]    w_pix_col;
  logic             w_pix_bit;
  logic [X_W:0]     w_x_sum;
  logic [Y_W:0]     w_y_sum;
  logic             w_clip;
  logic             w_pix_plot;
  logic [COL_W-1:0] w_pix_colour;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_FETCH;
          w_load = 1'b1;
        end
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_SCAN;
      S_SCAN: begin
        if (r_col == LAST_COL) w_next = (r_row == LAST_ROW) ? S_DONE : S_FETCH;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Out-of-range symbol indices fall back to symbol 0.
  assign w_sym_in    = ({1'b0, bus.sym_sel} < NUM_SYM_L) ? bus.sym_sel : '0;
  assign w_fetch_row = (r_state == S_IDLE) ? '0 : r_row + RW'(1);
  assign w_rom_addr  = ((r_state == S_IDLE) ? AW'(w_sym_in) : AW'(r_sym)) * SPR_H_A
                       + AW'(w_fetch_row);

  // Pixel registered on the edge that enters its SCAN cycle, so plot only ever shows in SCAN.
  assign w_pix_col = (r_state == S_WAIT) ? '0 : r_col + CW'(1);
  assign w_pix_bit = (r_state == S_WAIT) ? bus.rom_row[SPR_W-1] : r_shift[SPR_W-1];
  assign w_x_sum   = (X_W + 1)'(r_x) + (X_W + 1)'(w_pix_col);
  assign w_y_sum   = (Y_W + 1)'(r_y) + (Y_W + 1)'(r_row);
  assign w_clip    = (w_x_sum >= SCR_W_L) || (w_y_sum >= SCR_H_L);

  always_comb begin
    w_pix_plot   = w_pix_bit;
    w_pix_colour = r_bg;
    case (r_mode)
      2'b00:   w_pix_colour = r_fg;
      2'b01: begin
        w_pix_plot   = 1'b1;
        w_pix_colour = w_pix_bit ? r_fg : r_bg;
      end
      default: w_pix_colour = r_bg;
    endcase
    if (w_clip) w_pix_plot = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sym      <= '0;
      r_mode     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_fg       <= '0;
      r_bg       <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_shift    <= '0;
      r_rom_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_plot     <= 1'b0;
      r_xout     <= '0;
      r_yout     <= '0;
      r_colour   <= '0;
    end else begin
      if (w_load) begin
        r_sym  <= w_sym_in;
        r_mode <= bus.mode;
        r_x    <= bus.x;
        r_y    <= bus.y;
        r_fg   <= bus.fg_colour;
        r_bg   <= bus.bg_colour;
        r_row  <= '0;
        r_col  <= '0;
      end

      if (w_next == S_FETCH) r_rom_addr <= w_rom_addr;

      if (r_state == S_WAIT) begin
        r_shift <= bus.rom_row << 1;
        r_col   <= '0;
      end else if (r_state == S_SCAN) begin
        r_shift <= r_shift << 1;
        if (r_col == LAST_COL) begin
          r_col <= '0;
          if (r_row != LAST_ROW) r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end

      r_busy <= (w_next == S_FETCH) || (w_next == S_WAIT) || (w_next == S_SCAN);
      r_done <= (w_next == S_DONE);

      if (w_next == S_SCAN) begin
        r_plot   <= w_pix_plot;
        r_xout   <= w_x_sum[X_W-1:0];
        r_yout   <= w_y_sum[Y_W-1:0];
        r_colour <= w_pix_colour;
      end else begin
        r_plot   <= 1'b0;
      end
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.plot     = r_plot;
  assign bus.xout     = r_xout;
  assign bus.yout     = r_yout;
  assign bus.colour   = r_colour;
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter with 4x4 symbols: a pixel scoreboard filled from the bitmap model
// at each start, plus hand sequences for start-while-busy, restart after done and mid-blit reset.
module tb_sprite_blitter;
  localparam int SPR_W = 4, SPR_H = 4, NUM_SYM = 2;
  localparam int X_W = 8, Y_W = 7, COL_W = 3, SCREEN_W = 160, SCREEN_H = 120;
  localparam int BUSY_CYCLES = SPR_H * (SPR_W + 2);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_blitter_if #(.SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_SYM(NUM_SYM),
                      .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W)) bus ();

  sprite_blitter #(.SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_SYM(NUM_SYM), .X_W(X_W), .Y_W(Y_W),
                   .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .COL_W(COL_W))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  // Synchronous symbol ROM: sym0 = 1100,0011,1010,0101; sym1 = 1001,0110,0110,1001.
  logic [SPR_W-1:0] rom [NUM_SYM*SPR_H];
  always @(posedge clk) bus.rom_row <= rom[bus.rom_addr];

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] c;
  } pix_t;

  typedef struct {
    int sym; int mode; int x; int y; int fg; int bg; int n_plots; int chk_addr;
  } vec_t;

  pix_t exp_q[$];
  int   addr_log[$];
  int   checks = 0, errors = 0;
  int   plot_cnt, busy_cnt, done_cnt;
  vec_t vecs[5];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Independent pixel model: raster order, mode rules, clipping on unwrapped coordinates.
  function automatic void push_expected(input int sym, input int mode, input int x, input int y,
                                        input int fg, input int bg);
    logic [SPR_W-1:0] row;
    int b, p, col, xs, ys;
    pix_t e;
    for (int r = 0; r < SPR_H; r++) begin
      row = rom[sym*SPR_H + r];
      for (int c = 0; c < SPR_W; c++) begin
        b   = int'(row[SPR_W-1-c]);
        xs  = x + c;
        ys  = y + r;
        p   = (mode == 1) ? 1 : b;
        col = (mode == 0) ? fg : (mode == 1) ? (b != 0 ? fg : bg) : bg;
        if (p != 0 && xs < SCREEN_W && ys < SCREEN_H) begin
          e.x = X_W'(xs);
          e.y = Y_W'(ys);
          e.c = COL_W'(col);
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    pix_t e;
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.busy && (addr_log.size() == 0 || addr_log[$] != int'(bus.rom_addr)))
      addr_log.push_back(int'(bus.rom_addr));
    if (bus.plot) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL plot_extra got x=%0d y=%0d colour=%0d expected no plot",
                 bus.xout, bus.yout, bus.colour);
      end else begin
        e = exp_q.pop_front();
        check("plot_x", int'(bus.xout), int'(e.x));
        check("plot_y", int'(bus.yout), int'(e.y));
        check("plot_colour", int'(bus.colour), int'(e.c));
      end
    end
  end

  task automatic clear_counts();
    plot_cnt = 0;
    busy_cnt = 0;
    done_cnt = 0;
    addr_log.delete();
  endtask

  task automatic drive_inputs(input int sym, input int mode, input int x, input int y,
                              input int fg, input int bg);
    bus.sym_sel   = 1'(sym);
    bus.mode      = 2'(mode);
    bus.x         = X_W'(x);
    bus.y         = Y_W'(y);
    bus.fg_colour = COL_W'(fg);
    bus.bg_colour = COL_W'(bg);
  endtask

  task automatic start_blit(input int sym, input int mode, input int x, input int y,
                            input int fg, input int bg);
    @(negedge clk);
    drive_inputs(sym, mode, x, y, fg, bg);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns at the falling edge inside the DONE cycle, or after the cycle budget.
  task automatic wait_done();
    for (int i = 0; i < 300 && !bus.done; i++) @(negedge clk);
    check("done_seen", int'(bus.done), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_plot"}, int'(bus.plot), 0);
    check({tag, "_xout"}, int'(bus.xout), 0);
    check({tag, "_yout"}, int'(bus.yout), 0);
    check({tag, "_colour"}, int'(bus.colour), 0);
    check({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
  endtask

  task automatic run_vec(input vec_t v);
    clear_counts();
    push_expected(v.sym, v.mode, v.x, v.y, v.fg, v.bg);
    start_blit(v.sym, v.mode, v.x, v.y, v.fg, v.bg);
    wait_done();
    repeat (4) @(negedge clk);
    check("plot_count", plot_cnt, v.n_plots);
    check("busy_cycles", busy_cnt, BUSY_CYCLES);
    check("done_pulses", done_cnt, 1);
    check("exp_left", exp_q.size(), 0);
    exp_q.delete();
    if (v.chk_addr != 0) begin
      check("addr_count", addr_log.size(), SPR_H);
      for (int i = 0; i < addr_log.size(); i++)
        check("rom_addr_seq", addr_log[i], v.sym*SPR_H + i);
    end
  endtask

  initial begin
    rom[0] = 4'b1100; rom[1] = 4'b0011; rom[2] = 4'b1010; rom[3] = 4'b0101;
    rom[4] = 4'b1001; rom[5] = 4'b0110; rom[6] = 4'b0110; rom[7] = 4'b1001;

    //           sym mode  x    y   fg bg plots addr
    vecs[0] = '{1,  0,   10,  20, 3, 0, 8,   0};
    vecs[1] = '{1,  1,   10,  20, 3, 0, 16,  0};
    vecs[2] = '{1,  2,   10,  20, 3, 0, 8,   1};
    vecs[3] = '{1,  1,   158, 118, 3, 0, 4,  0};
    vecs[4] = '{0,  3,   0,   0,  5, 6, 8,   1};

    reset = 1'b1;
    bus.start = 1'b0;
    drive_inputs(0, 0, 0, 0, 0, 0);
    clear_counts();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start pulsed mid-blit with different inputs is ignored; start over DONE edge is too.
    clear_counts();
    push_expected(1, 0, 10, 20, 3, 0);
    start_blit(1, 0, 10, 20, 3, 0);
    repeat (5) @(negedge clk);
    drive_inputs(0, 1, 50, 60, 7, 5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    push_expected(0, 0, 30, 40, 4, 1);
    drive_inputs(0, 0, 30, 40, 4, 1);
    bus.start = 1'b1;
    @(negedge clk);
    check("busy_after_done_edge", int'(bus.busy), 0);
    check("midstart_plots", plot_cnt, 8);
    check("midstart_done", done_cnt, 1);
    check("midstart_busy", busy_cnt, BUSY_CYCLES);
    clear_counts();
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_busy", int'(bus.busy), 1);
    wait_done();
    repeat (4) @(negedge clk);
    check("restart_plots", plot_cnt, 8);
    check("restart_busy_cycles", busy_cnt, BUSY_CYCLES);
    check("restart_done", done_cnt, 1);
    check("restart_exp_left", exp_q.size(), 0);
    exp_q.delete();

    // Reset during row 2 of an opaque blit aborts it.
    clear_counts();
    push_expected(1, 1, 10, 20, 3, 0);
    start_blit(1, 1, 10, 20, 3, 0);
    for (int i = 0; i < 300 && !(bus.plot && bus.yout == 7'd22); i++) @(negedge clk);
    check("row2_reached", int'(bus.yout), 22);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("midreset_done", done_cnt, 0);
    check("midreset_plots", plot_cnt, 2*SPR_W + 1);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
